early_z_fetch: RTL



---
 rtl/gpu_render_pkg.sv | 19 +
 rtl/early_z_fetch_if.sv | 28 ++
 rtl/early_z_addr_gen.sv | 20 ++
 rtl/early_z_fetch.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/gpu_render_pkg.sv
// Shared render-pipeline types: Z-fetch entry states and Z-test constants.
package gpu_render_pkg;

  typedef enum logic [1:0] {
    StEmpty,
    StIssue,
    StWait,
    StReady
  } entry_state_e;

  localparam logic [2:0]  CMP_ALWAYS = 3'b110;
  localparam logic [15:0] ZBUF_CLEAR = 16'hFFFF;

  // A fragment skips the Z-buffer read when its test result cannot depend on stored depth.
  function automatic logic z_bypass(input logic test_en, input logic [2:0] cmp);
    return !test_en || (cmp == CMP_ALWAYS);
  endfunction

endpackage

// File: rtl/early_z_fetch_if.sv
// Z-buffer read port: in-order requests with ack, in-order data returns.
interface early_z_fetch_if #(
  parameter int unsigned ADDR_W = 24
) ();

  logic              rd_req;
  logic [ADDR_W-1:0] rd_addr;
  logic              rd_ack;
  logic              rd_data_valid;
  logic [15:0]       rd_data;

  modport master (
    output rd_req,
    output rd_addr,
    input  rd_ack,
    input  rd_data_valid,
    input  rd_data
  );

  modport slave (
    input  rd_req,
    input  rd_addr,
    output rd_ack,
    output rd_data_valid,
    output rd_data
  );

endinterface

// File: rtl/early_z_addr_gen.sv
// Z-buffer word address from pixel coordinates; wraps modulo 2^ADDR_W.
module early_z_addr_gen #(
  parameter int unsigned ADDR_W        = 24,
  parameter int unsigned FB_WIDTH_LOG2 = 9
) (
  input  logic [ADDR_W-1:0] base_i,
  input  logic [9:0]        x_i,
  input  logic [9:0]        y_i,
  output logic [ADDR_W-1:0] addr_o
);

  logic [ADDR_W-1:0] row_off;

  // base + y * pitch + x, truncated to the port width
  always_comb begin
    row_off = ADDR_W'(y_i) << FB_WIDTH_LOG2;
    addr_o  = base_i + row_off + ADDR_W'(x_i);
  end

endmodule

// File: rtl/early_z_fetch.sv
// Early-Z fetch: pairs each fragment with its stored depth through an in-order
// reorder buffer. Optional counters enabled by defining EARLY_Z_FETCH_STATS_EN.
module early_z_fetch
  import gpu_render_pkg::*;
#(
  parameter int unsigned ADDR_W        = 24,
  parameter int unsigned FB_WIDTH_LOG2 = 9,
  parameter int unsigned DATA_W        = 32,
  parameter int unsigned FIFO_DEPTH    = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              frag_valid,
  output logic              frag_ready,
  input  logic [9:0]        frag_x,
  input  logic [9:0]        frag_y,
  input  logic [15:0]       frag_z,
  input  logic [DATA_W-1:0] frag_data,
  input  logic [ADDR_W-1:0] zbuf_base,
  input  logic              z_test_en,
  input  logic [2:0]        z_compare,
  early_z_fetch_if.master   mem,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [9:0]        out_x,
  output logic [9:0]        out_y,
  output logic [15:0]       out_z,
  output logic [15:0]       out_zbuf_z,
  output logic [DATA_W-1:0] out_data,
  output logic              out_bypass,
`ifdef EARLY_Z_FETCH_STATS_EN
  output logic [31:0]       stat_frags,
  output logic [31:0]       stat_reads,
  output logic [31:0]       stat_stall,
`endif
  output logic              rd_overflow
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  typedef logic [PTR_W-1:0] ptr_t;
  typedef logic [PTR_W:0]   cnt_t;

  entry_state_e      state_q [FIFO_DEPTH];
  entry_state_e      state_d [FIFO_DEPTH];
  logic [9:0]        x_q     [FIFO_DEPTH];
  logic [9:0]        y_q     [FIFO_DEPTH];
  logic [15:0]       z_q     [FIFO_DEPTH];
  logic [15:0]       zbuf_q  [FIFO_DEPTH];
  logic [DATA_W-1:0] data_q  [FIFO_DEPTH];
  logic [ADDR_W-1:0] addr_q  [FIFO_DEPTH];
  logic              byp_q   [FIFO_DEPTH];

  ptr_t wr_ptr_q, head_q, issue_q;
  cnt_t count_q;
  logic overflow_q;

  logic              accept, pop, bypass, ack_fire, issue_adv, fill;
  logic              ret_found;
  ptr_t              ret_idx, scan_idx;
  logic [ADDR_W-1:0] frag_addr;

  early_z_addr_gen #(
    .ADDR_W        (ADDR_W),
    .FB_WIDTH_LOG2 (FB_WIDTH_LOG2)
  ) u_addr_gen (
    .base_i (zbuf_base),
    .x_i    (frag_x),
    .y_i    (frag_y),
    .addr_o (frag_addr)
  );

  // Handshakes and issue-pointer movement; the issue pointer skips bypass entries.
  always_comb begin
    frag_ready  = (count_q != cnt_t'(FIFO_DEPTH));
    accept      = frag_valid && frag_ready;
    bypass      = z_bypass(z_test_en, z_compare);
    out_valid   = (state_q[head_q] == StReady);
    pop         = out_valid && out_ready;
    mem.rd_req  = (state_q[issue_q] == StIssue);
    mem.rd_addr = addr_q[issue_q];
    ack_fire    = mem.rd_req && mem.rd_ack;
    issue_adv   = ack_fire || ((state_q[issue_q] == StReady) && byp_q[issue_q]);
    rd_overflow = overflow_q;
  end

  // Oldest WAIT entry, scanning from head in allocation order, takes the next return.
  always_comb begin
    ret_found = 1'b0;
    ret_idx   = '0;
    scan_idx  = '0;
    for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
      scan_idx = head_q + ptr_t'(i);
      if (!ret_found && (state_q[scan_idx] == StWait)) begin
        ret_found = 1'b1;
        ret_idx   = scan_idx;
      end
    end
    fill = mem.rd_data_valid && ret_found;
  end

  // Entry state transitions; the four events always target distinct entries.
  always_comb begin
    state_d = state_q;
    if (ack_fire) state_d[issue_q] = StWait;
    if (fill)     state_d[ret_idx] = StReady;
    if (pop)      state_d[head_q]  = StEmpty;
    if (accept)   state_d[wr_ptr_q] = bypass ? StReady : StIssue;
  end

  // Entry states, pointers, occupancy and sticky overflow.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) state_q[i] <= StEmpty;
      wr_ptr_q   <= '0;
      head_q     <= '0;
      issue_q    <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_q + ptr_t'(accept);
      head_q   <= head_q + ptr_t'(pop);
      issue_q  <= issue_q + ptr_t'(issue_adv);
      count_q  <= count_q + cnt_t'(accept) - cnt_t'(pop);
      if (mem.rd_data_valid && !ret_found) overflow_q <= 1'b1;
    end
  end

  // Entry payload storage; stored depth arrives either at accept (bypass) or on return.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
        x_q[i]    <= '0;
        y_q[i]    <= '0;
        z_q[i]    <= '0;
        zbuf_q[i] <= '0;
        data_q[i] <= '0;
        addr_q[i] <= '0;
        byp_q[i]  <= 1'b0;
      end
    end else begin
      if (accept) begin
        x_q[wr_ptr_q]    <= frag_x;
        y_q[wr_ptr_q]    <= frag_y;
        z_q[wr_ptr_q]    <= frag_z;
        data_q[wr_ptr_q] <= frag_data;
        addr_q[wr_ptr_q] <= frag_addr;
        byp_q[wr_ptr_q]  <= bypass;
        zbuf_q[wr_ptr_q] <= bypass ? ZBUF_CLEAR : 16'h0000;
      end
      if (fill) zbuf_q[ret_idx] <= mem.rd_data;
    end
  end

  // Head entry drives the output directly, so it holds while the consumer stalls.
  always_comb begin
    out_x      = x_q[head_q];
    out_y      = y_q[head_q];
    out_z      = z_q[head_q];
    out_zbuf_z = zbuf_q[head_q];
    out_data   = data_q[head_q];
    out_bypass = byp_q[head_q];
  end

`ifdef EARLY_Z_FETCH_STATS_EN
  // Saturating activity counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_frags <= '0;
      stat_reads <= '0;
      stat_stall <= '0;
    end else begin
      if (accept && (stat_frags != '1)) stat_frags <= stat_frags + 32'd1;
      if (ack_fire && (stat_reads != '1)) stat_reads <= stat_reads + 32'd1;
      if (frag_valid && !frag_ready && (stat_stall != '1)) stat_stall <= stat_stall + 32'd1;
    end
  end
`endif

endmodule
